// File: rtl/add_nbit_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a slice with a registered
// carry; sum, raw carry and signed overflow are returned with a one-cycle valid pulse.
module add_nbit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  logic             sub_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             valid_out
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   slice_s;
  logic [WIDTH-1:0] slice_ext_s;
  logic             msb_cin_s;
  logic             last_s;

  // Digit slice; on the final digit its top bit is the word MSB, so the carry into it feeds overflow.
  always_comb begin
    slice_s     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    slice_ext_s = '0;
    slice_ext_s[DIGIT-1:0] = slice_s[DIGIT-1:0];
    msb_cin_s   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_s[DIGIT-1];
    last_s      = (cnt_q == LAST_DIGIT);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          // Subtraction is A + ~B + ~borrow, so the inverted borrow seeds the carry.
          a_d     = a_in;
          b_d     = sub_in ? ~b_in : b_in;
          carry_d = sub_in ^ carry_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = slice_s[DIGIT];
        acc_d   = (acc_q >> DIGIT) | (slice_ext_s << (WIDTH - DIGIT));
        cnt_d   = cnt_q + CW'(1);
        if (last_s) begin
          sum_d   = acc_d;
          cout_d  = slice_s[DIGIT];
          ovf_d   = msb_cin_s ^ slice_s[DIGIT];
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_out    = (state_q == S_IDLE);
  assign sum_out      = sum_q;
  assign carry_out    = cout_q;
  assign overflow_out = ovf_q;
  assign valid_out    = valid_q;

endmodule

// File: tb/tb_add_nbit_serial.sv
// Directed bench for the 16/4 serial adder plus random sweeps over other WIDTH/DIGIT pairs.
module tb_add_nbit_serial;

  logic        clk;
  logic        rst;
  logic [15:0] a_in, b_in, sum_out;
  logic        carry_in, sub_in, valid_in;
  logic        ready_out, carry_out, overflow_out, valid_out;

  int n_checks = 0;
  int n_errors = 0;
  int sweep_done = 0;

  add_nbit_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .carry_in(carry_in), .sub_in(sub_in),
    .valid_in(valid_in), .ready_out(ready_out), .sum_out(sum_out), .carry_out(carry_out),
    .overflow_out(overflow_out), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {carry, overflow, sum}; overflow from operand/result sign comparison.
  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic su, input int w);
    logic [31:0] mask, bb, s;
    logic [32:0] full;
    logic        c, v;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    bb   = (su ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, bb} + {32'd0, su ^ ci};
    s    = full[31:0] & mask;
    c    = full[w];
    v    = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {c, v, s};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic su, input logic [15:0] es,
                        input logic ec, input logic ev);
    int lat;
    int rdy_lo;
    check({tag, "_rdy_pre"}, 64'(ready_out), 64'd1);
    a_in = a; b_in = b; carry_in = ci; sub_in = su; valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    lat = 1;
    rdy_lo = ready_out ? 0 : 1;
    while (!valid_out && lat < 20) begin
      a_in = a_in ^ 16'hA5A5; b_in = ~b_in; sub_in = ~sub_in;
      @(negedge clk);
      lat++;
      if (!ready_out) rdy_lo++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_rdy_lo"}, 64'(rdy_lo), 64'd5);
    check({tag, "_sum"}, 64'(sum_out), 64'(es));
    check({tag, "_cout"}, 64'(carry_out), 64'(ec));
    check({tag, "_ovf"}, 64'(overflow_out), 64'(ev));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(valid_out), 64'd0);
    check({tag, "_rdy_post"}, 64'(ready_out), 64'd1);
    check({tag, "_hold"}, 64'(sum_out), 64'(es));
  endtask

  initial begin
    logic [33:0] e;
    logic [33:0] q_exp[$];
    int          acc_cyc[$];
    int          n_res;
    int          vcount;
    rst = 1'b1; valid_in = 1'b0; a_in = 16'h0; b_in = 16'h0; carry_in = 1'b0; sub_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_sum", 64'(sum_out), 64'd0);
    check("rst_cout", 64'(carry_out), 64'd0);
    check("rst_ovf", 64'(overflow_out), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t2a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("t2b", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    run_op("t3a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("t3b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // valid_in held high, operands changing every cycle
    n_res = 0;
    valid_in = 1'b1;
    for (int cyc = 0; cyc < 40 && n_res < 3; cyc++) begin
      a_in = 16'($urandom); b_in = 16'($urandom);
      carry_in = 1'($urandom); sub_in = 1'($urandom);
      if (ready_out) begin
        q_exp.push_back(ref_add({16'd0, a_in}, {16'd0, b_in}, carry_in, sub_in, 16));
        acc_cyc.push_back(cyc);
      end
      @(negedge clk);
      if (valid_out) begin
        n_res++;
        if (q_exp.size() == 0) begin
          check("t4_queue", 64'd0, 64'd1);
        end else begin
          e = q_exp.pop_front();
          check("t4_sum", 64'(sum_out), 64'(e[15:0]));
          check("t4_ovf", 64'(overflow_out), 64'(e[32]));
          check("t4_cout", 64'(carry_out), 64'(e[33]));
        end
      end
    end
    valid_in = 1'b0;
    check("t4_results", 64'(n_res), 64'd3);
    if (acc_cyc.size() >= 3) begin
      check("t4_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
      check("t4_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);
    end else begin
      check("t4_accepts", 64'(acc_cyc.size()), 64'd3);
    end
    @(negedge clk);

    // reset after two RUN digits
    check("t5_rdy_pre", 64'(ready_out), 64'd1);
    a_in = 16'h1111; b_in = 16'h2222; carry_in = 1'b0; sub_in = 1'b0; valid_in = 1'b1;
    @(posedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready", 64'(ready_out), 64'd1);
    check("t5_sum", 64'(sum_out), 64'd0);
    check("t5_cout", 64'(carry_out), 64'd0);
    check("t5_ovf", 64'(overflow_out), 64'd0);
    vcount = 0;
    repeat (8) begin
      if (valid_out) vcount++;
      @(negedge clk);
    end
    check("t5_no_pulse", 64'(vcount), 64'd0);
    run_op("t5c", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    for (int k = 0; k < 60000 && sweep_done < 4; k++) @(negedge clk);
    check("sweep_done", 64'(sweep_done), 64'd4);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 16 : (g == 1) ? 16 : (g == 2) ? 8 : 32;
    localparam int SD = (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
    localparam int SN = SW / SD;
    logic [SW-1:0] sa, sb, ss;
    logic          srst, sci, ssu, svi, sro, sco, sov, svo;

    add_nbit_serial #(.WIDTH(SW), .DIGIT(SD)) u_sweep (
      .clk(clk), .rst(srst), .a_in(sa), .b_in(sb), .carry_in(sci), .sub_in(ssu),
      .valid_in(svi), .ready_out(sro), .sum_out(ss), .carry_out(sco),
      .overflow_out(sov), .valid_out(svo)
    );

    initial begin
      logic [33:0] e;
      logic [31:0] ra, rb;
      int          lat;
      srst = 1'b1; svi = 1'b0; sa = '0; sb = '0; sci = 1'b0; ssu = 1'b0;
      repeat (3) @(negedge clk);
      srst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        ra = (i == 0) ? 32'hFFFF_FFFF : $urandom;
        rb = (i == 0) ? 32'h0000_0001 : $urandom;
        sa = ra[SW-1:0]; sb = rb[SW-1:0];
        sci = 1'($urandom); ssu = 1'($urandom);
        e = ref_add(ra, rb, sci, ssu, SW);
        check($sformatf("sw%0d_rdy", g), 64'(sro), 64'd1);
        svi = 1'b1;
        @(posedge clk);
        @(negedge clk);
        svi = 1'b0;
        sa = ~sa; sb = ~sb; sci = ~sci; ssu = ~ssu;
        lat = 1;
        while (!svo && lat < SN + 10) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("sw%0d_lat", g), 64'(lat), 64'(SN + 1));
        check($sformatf("sw%0d_sum", g), 64'(ss), 64'(e[31:0]));
        check($sformatf("sw%0d_ovf", g), 64'(sov), 64'(e[32]));
        check($sformatf("sw%0d_cout", g), 64'(sco), 64'(e[33]));
      end
      sweep_done++;
    end
  end

endmodule

// File: doc/add_nbit_serial.md
Name: add_nbit_serial

Overview:
Parametrised digit-serial adder/subtractor, the multi-cycle successor to the team's 4-bit combinational adder. It takes two WIDTH-bit operands through a valid/ready handshake and processes DIGIT bits per clock through a DIGIT-bit adder slice with a registered carry. It returns sum, carry and signed overflow with a one-cycle valid pulse. It is used wherever a wide add/sub is needed but a full-width ripple path cannot close timing or area.

Parameters:
WIDTH, 16, operand and result width in bits; must be ≥1 and an integer multiple of DIGIT.
DIGIT, 4, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT is the run length in cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
a_in  input  WIDTH  operand A, sampled on accept only.
b_in  input  WIDTH  operand B, sampled on accept only.
carry_in  input  1  carry-in (add) / borrow-in (sub), sampled on accept.
sub_in  input  1  0 = A+B+cin, 1 = A−B−cin; sampled on accept.
valid_in  input  1  request; accepted on a clk edge where valid_in && ready_out.
ready_out  output  1  high only in IDLE.
sum_out  output  WIDTH  result, registered, held until the next completion.
carry_out  output  1  raw carry out of MSB; in sub mode 1 = no borrow.
overflow_out  output  1  signed (two's complement) overflow.
valid_out  output  1  one-cycle pulse when the result registers update.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on rising clk.
- Reset: state=IDLE, sum_out=0, carry_out=0, overflow_out=0, valid_out=0, digit counter=0, internal shift registers=0. rst has priority over every other event, including mid-RUN. A run in progress is discarded with no valid_out.
- FSM states are IDLE, RUN and DONE.
- IDLE: ready_out=1.
  - On valid_in=1, latch A, and B' = sub_in ? ~B : B.
  - Set carry register = sub_in ? ~carry_in : carry_in.
  - Counter=0, then go to RUN.
  - With valid_in=0, stay in IDLE.
- RUN: ready_out=0. Each cycle:
  - Add the low DIGIT bits of A, B' and the carry register.
  - Shift the DIGIT-bit sum into the top of the result shift register.
  - Shift A and B' right by DIGIT and update the carry register.
  - On the final digit (counter==NDIG−1), also capture the MSB carry-in for overflow, then go to DONE.
- DONE: ready_out=0 for this cycle.
  - sum_out, carry_out and overflow_out were loaded on the edge entering DONE; valid_out=1 for exactly this cycle.
  - Next edge returns to IDLE.
- Latency: accept edge E; valid_out is high in the cycle after edge E+NDIG. Throughput is one op per NDIG+2 cycles.
- overflow_out = carry into MSB XOR carry out of MSB (final adder stage).
- Width rules: all arithmetic is modulo 2^WIDTH; no sign extension. The carry register is 1 bit between digits.
- Inputs (a_in, b_in, sub_in, carry_in, valid_in) are ignored outside IDLE; changing them during RUN has no effect.
- valid_in held high continuously: the next operation is accepted on the first IDLE edge after DONE.
- Degenerate DIGIT=WIDTH: NDIG=1, RUN lasts one cycle, valid_out in the cycle after edge E+1.
- sum_out, carry_out and overflow_out are stable outside the DONE update edge; they are not cleared on a new accept.

Test Plan:
1. WIDTH=16, DIGIT=4: A=0xFFFF, B=0x0001, sub=0, cin=0 -> sum_out=0x0000, carry_out=1, overflow_out=0. valid_out pulses exactly 1 cycle, in the cycle after accept+4 edges. ready_out low for 5 cycles.
2. Signed overflow and cin: A=0x7FFF, B=0x0001 -> 0x8000, carry_out=0, overflow_out=1. Then A=0x1234, B=0x1111, cin=1 -> 0x2346, carry_out=0, overflow_out=0.
3. Subtract: A=0x0005, B=0x0007, sub=1, cin=0 -> 0xFFFE, carry_out=0 (borrow), overflow_out=0. A=0x8000, B=0x0001, sub=1 -> 0x7FFF, carry_out=1, overflow_out=1.
4. valid_in held high with new operands every cycle -> accepts exactly one op per 6 cycles. Each result matches the operands sampled on its accept edge. Operand changes during RUN do not affect the result.
5. rst asserted after 2 RUN digits -> next cycle: state IDLE, ready_out=1, sum_out=0, carry_out=0, overflow_out=0. No valid_out pulse. The following op completes correctly.
6. Parameter sweep (WIDTH,DIGIT) = (16,16), (16,1), (8,2), (32,8): 1000 random ops each, including sub and cin, checked against a reference model. Latency checked = NDIG cycles from accept to valid_out.
